// File: rtl/lcd_pkg.sv
// Shared LCD controller constants and the frame output state encoding.
package lcd_pkg;

    localparam int unsigned LCD_DATA_W = 8;
    localparam int unsigned LCD_ADDR_W = 6;
    localparam int unsigned LCD_PIX_N  = 64;
    localparam int unsigned LCD_CSUM_W = 16;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_STREAM  = 2'd1,
        ST_FINISH  = 2'd2,
        ST_ERR     = 2'd3
    } frame_out_state_t;

endpackage

// File: rtl/lcd_frame_buf.sv
// 8x8 frame buffer: one write port, one registered read port with write-first forwarding.
module lcd_frame_buf
    import lcd_pkg::*;
#(
    parameter int unsigned DATA_W = LCD_DATA_W,
    parameter int unsigned ADDR_W = LCD_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_frame_out.sv
// Captures a 64-pixel write burst, then streams it row-major over valid/ready
// while accumulating an additive checksum of accepted beats.
module lcd_frame_out
    import lcd_pkg::*;
#(
    parameter int unsigned DATA_W = LCD_DATA_W,
    parameter int unsigned ADDR_W = LCD_ADDR_W,
    parameter int unsigned CSUM_W = LCD_CSUM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IRAM_valid,
    input  logic [ADDR_W-1:0] IRAM_A,
    input  logic [DATA_W-1:0] IRAM_D,
    input  logic              done,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_last,
    output logic [CSUM_W-1:0] csum,
    output logic              frame_ok,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned       DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

    frame_out_state_t  state_q;
    logic [DEPTH-1:0]  bitmap_q;
    logic [DEPTH-1:0]  bitmap_d;
    logic [ADDR_W-1:0] ptr_q;
    logic              pix_valid_q;
    logic              pix_last_q;
    logic              frame_ok_q;
    logic              frame_err_q;
    logic              overrun_q;
    logic [CSUM_W-1:0] csum_q;

    logic              in_cap_c;
    logic              wr_c;
    logic              full_c;
    logic              start_c;
    logic              accept_c;
    logic              re_c;
    logic [ADDR_W-1:0] ptr_nxt_c;
    logic [ADDR_W-1:0] raddr_c;
    logic [DATA_W-1:0] rdata_c;

    // Writes land only while capturing; the full test includes this cycle's write.
    assign in_cap_c  = (state_q == ST_CAPTURE);
    assign wr_c      = reset && in_cap_c && IRAM_valid;
    assign bitmap_d  = wr_c ? (bitmap_q | (DEPTH'(1) << IRAM_A)) : bitmap_q;
    assign full_c    = &bitmap_d;
    assign start_c   = in_cap_c && done && full_c;
    assign accept_c  = (state_q == ST_STREAM) && pix_ready;
    assign ptr_nxt_c = ptr_q + ADDR_W'(1);
    assign re_c      = start_c || (accept_c && !pix_last_q);
    assign raddr_c   = start_c ? '0 : ptr_nxt_c;

    lcd_frame_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_c),
        .waddr_i (IRAM_A),
        .wdata_i (IRAM_D),
        .re_i    (re_c),
        .raddr_i (raddr_c),
        .rdata_o (rdata_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_CAPTURE;
            bitmap_q    <= '0;
            ptr_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            csum_q      <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (IRAM_valid && !in_cap_c) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                ST_CAPTURE: begin
                    bitmap_q <= bitmap_d;
                    if (done) begin
                        if (full_c) begin
                            state_q     <= ST_STREAM;
                            ptr_q       <= '0;
                            pix_valid_q <= 1'b1;
                            pix_last_q  <= 1'b0;
                        end else begin
                            state_q     <= ST_ERR;
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (accept_c) begin
                        csum_q <= csum_q + CSUM_W'(rdata_c);
                        if (pix_last_q) begin
                            state_q     <= ST_FINISH;
                            pix_valid_q <= 1'b0;
                            pix_last_q  <= 1'b0;
                            frame_ok_q  <= 1'b1;
                        end else begin
                            ptr_q      <= ptr_nxt_c;
                            pix_last_q <= (ptr_nxt_c == LAST_A);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_data  = rdata_c;
    assign pix_last  = pix_last_q;
    assign csum      = csum_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
